// File: rtl/config_loader.sv
`default_nettype none
// ============================================================================
//  Module      : config_loader
//  Description : Write-side sequencer for the neuron configuration memories.
//                Parses a header word (target, length, start address) from a
//                32-bit config stream and issues one registered, one-hot
//                write strobe per payload word with an auto-incrementing
//                address. Stalls while the neuron core is busy.
//  Revision    : 1.0 - initial release
// ============================================================================
module config_loader #(
    parameter int DSIZE                   = 16,
    parameter int NURN_CNT_BIT_WIDTH      = 8,
    parameter int AXON_CNT_BIT_WIDTH      = 8,
    parameter int CONFIG_PARAMETER_NUMBER = 9
) (
    input  logic                                         clk_i,
    input  logic                                         rst_n_i,
    input  logic [2*DSIZE-1:0]                           cfg_data_i,
    input  logic                                         cfg_valid_i,
    output logic                                         cfg_ready_o,
    input  logic                                         core_busy_i,
    input  logic                                         abort_i,
    output logic [2*DSIZE-1:0]                           config_data_o,
    output logic [CONFIG_PARAMETER_NUMBER-1:0]           config_write_enable_o,
    output logic [NURN_CNT_BIT_WIDTH+AXON_CNT_BIT_WIDTH-1:0] config_addr_o,
    output logic                                         ce_o,
    output logic                                         busy_o,
    output logic                                         done_o,
    output logic                                         err_o
);

    localparam int c_ADDR_W = NURN_CNT_BIT_WIDTH + AXON_CNT_BIT_WIDTH;
    localparam logic [CONFIG_PARAMETER_NUMBER-1:0] c_ONE =
        {{(CONFIG_PARAMETER_NUMBER-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_WRITE = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t r_state;
    state_t w_next;

    // Latched packet context
    logic [3:0]          r_target;
    logic                r_invalid;
    logic [11:0]         r_remain;
    logic [c_ADDR_W-1:0] r_addr;

    // Registered write port and status outputs
    logic [CONFIG_PARAMETER_NUMBER-1:0] r_we;
    logic [2*DSIZE-1:0]                 r_data;
    logic [c_ADDR_W-1:0]                r_waddr;
    logic                               r_ce;
    logic                               r_done;
    logic                               r_err;

    // Header field decode (only meaningful in IDLE)
    logic [3:0]  w_hdr_target;
    logic [11:0] w_hdr_len;
    logic [15:0] w_hdr_addr;
    logic        w_hdr_invalid;

    // Control decoded from state and handshake
    logic w_ready;
    logic w_accept;
    logic w_load;
    logic w_wr;
    logic w_dec;
    logic w_done;
    logic w_err;

    assign w_hdr_target  = cfg_data_i[31:28];
    assign w_hdr_len     = cfg_data_i[27:16];
    assign w_hdr_addr    = cfg_data_i[15:0];
    assign w_hdr_invalid = (32'(w_hdr_target) >= 32'(CONFIG_PARAMETER_NUMBER));

    // Next-state and per-cycle control; ready never looks at cfg_valid_i
    always_comb begin
        w_next   = r_state;
        w_ready  = 1'b0;
        w_load   = 1'b0;
        w_wr     = 1'b0;
        w_dec    = 1'b0;
        w_done   = 1'b0;
        w_err    = 1'b0;
        w_accept = 1'b0;

        case (r_state)
            S_IDLE: begin
                w_ready  = 1'b1;
                w_accept = cfg_valid_i;
                if (w_accept) begin
                    w_load = 1'b1;
                    if (w_hdr_len == 12'd0) begin
                        w_next = S_DONE;
                        w_done = 1'b1;
                        w_err  = w_hdr_invalid;
                    end else if (w_hdr_invalid) begin
                        w_next = S_DRAIN;
                    end else begin
                        w_next = S_WRITE;
                    end
                end
            end
            S_WRITE: begin
                w_ready  = !core_busy_i;
                w_accept = cfg_valid_i && w_ready;
                if (abort_i) begin
                    // Word taken alongside abort is swallowed without a strobe
                    w_next = S_IDLE;
                end else if (w_accept) begin
                    w_wr  = 1'b1;
                    w_dec = 1'b1;
                    if (r_remain == 12'd1) begin
                        w_next = S_DONE;
                        w_done = 1'b1;
                    end
                end
            end
            S_DRAIN: begin
                w_ready  = 1'b1;
                w_accept = cfg_valid_i;
                if (abort_i) begin
                    w_next = S_IDLE;
                end else if (w_accept) begin
                    w_dec = 1'b1;
                    if (r_remain == 12'd1) begin
                        w_next = S_DONE;
                        w_done = 1'b1;
                        w_err  = r_invalid;
                    end
                end
            end
            S_DONE: begin
                // One-cycle bubble so a new header never overlaps done_o
                w_next = S_IDLE;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    // State register
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Packet context: header latch, remaining count and address counter
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_target  <= 4'd0;
            r_invalid <= 1'b0;
            r_remain  <= 12'd0;
            r_addr    <= '0;
        end else if (w_load) begin
            r_target  <= w_hdr_target;
            r_invalid <= w_hdr_invalid;
            r_remain  <= w_hdr_len;
            r_addr    <= w_hdr_addr[c_ADDR_W-1:0];
        end else begin
            if (w_dec) begin
                r_remain <= r_remain - 12'd1;
            end
            if (w_wr) begin
                // Wraps naturally at the top of the address space
                r_addr <= r_addr + 1'b1;
            end
        end
    end

    // Registered write port: strobe lives exactly one cycle per accepted word
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_we    <= '0;
            r_ce    <= 1'b0;
            r_data  <= '0;
            r_waddr <= '0;
        end else if (w_wr) begin
            r_we    <= c_ONE << r_target;
            r_ce    <= 1'b1;
            r_data  <= cfg_data_i;
            r_waddr <= r_addr;
        end else begin
            r_we    <= '0;
            r_ce    <= 1'b0;
        end
    end

    // Registered completion pulses, aligned with the final strobe
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_done <= 1'b0;
            r_err  <= 1'b0;
        end else begin
            r_done <= w_done;
            r_err  <= w_err;
        end
    end

    assign cfg_ready_o           = rst_n_i && w_ready;
    assign config_data_o         = r_data;
    assign config_write_enable_o = r_we;
    assign config_addr_o         = r_waddr;
    assign ce_o                  = r_ce;
    assign busy_o                = (r_state != S_IDLE);
    assign done_o                = r_done;
    assign err_o                 = r_err;

endmodule
`default_nettype wire

// File: doc/config_loader.md
# config_loader

Write-side sequencer for the neuron configuration memories. It accepts a stream of 32-bit configuration words and parses a header word that selects the target memory, start address and payload length. It then drives one-hot write enables, write data and an auto-incrementing address into the config memory write port, one payload word per write cycle. It sits between the NoC configuration packet path and the per-core configuration memory, and stalls while the neuron core is busy.

## Interface
Parameters:
- DSIZE, 16, data word size; stream and write data are 2*DSIZE bits.
- NURN_CNT_BIT_WIDTH, 8, neuron address width.
- AXON_CNT_BIT_WIDTH, 8, axon address width.
- CONFIG_PARAMETER_NUMBER, 9, number of writable config targets; width of the write-enable vector.

Ports:
- clk_i  in  1  clock.
- rst_n_i  in  1  reset, asynchronous, active-low.
- cfg_data_i  in  2*DSIZE  stream word (header or payload).
- cfg_valid_i  in  1  stream word valid.
- cfg_ready_o  out  1  loader can accept a word.
- core_busy_i  in  1  neuron core running; writes must be held off.
- abort_i  in  1  synchronous abort of the current packet.
- config_data_o  out  2*DSIZE  write data to config memory.
- config_write_enable_o  out  CONFIG_PARAMETER_NUMBER  one-hot write strobe.
- config_addr_o  out  NURN_CNT_BIT_WIDTH+AXON_CNT_BIT_WIDTH  write address; neuron id is in the upper bits.
- ce_o  out  1  memory clock enable; high in any cycle with a write strobe.
- busy_o  out  1  a packet is in progress (state not IDLE).
- done_o  out  1  one-cycle pulse at the end of a packet.
- err_o  out  1  one-cycle pulse, coincident with done_o, when the packet's target was invalid.

## Operation
- Header fields:
  - [31:28] target T.
  - [27:16] payload length L, range 0..4095.
  - [15:0] start address A; bits above the address width are ignored.
- States:
  - IDLE: cfg_ready_o=1. An accepted word is the header: latch T, L, A.
    - L=0 -> DONE.
    - T>=CONFIG_PARAMETER_NUMBER and L>0 -> DRAIN.
    - Otherwise -> WRITE.
  - WRITE: cfg_ready_o = !core_busy_i.
    - Each accepted word (valid & ready) registers data, sets enable bit T, drives the address, then increments the address.
    - On the L-th accepted word -> DONE.
  - DRAIN: cfg_ready_o=1. Accepted words are discarded with no strobes. On the L-th word -> DONE.
  - DONE: cfg_ready_o=0 (one bubble). Assert done_o; assert err_o if T was invalid. -> IDLE.
- Remaining count is a 12-bit down-counter loaded with L and decremented per accepted payload word.
- The address counter wraps modulo 2^(NURN_CNT_BIT_WIDTH+AXON_CNT_BIT_WIDTH) with no error.
- abort_i, in any state other than IDLE: next state IDLE, no done_o, no further strobes. A word accepted in the same cycle as abort_i is discarded. abort_i in IDLE has no effect.
- A core_busy_i rise mid-packet only stalls (cfg_ready_o falls). Counters, address and state are held.

## Timing
- Reset values: cfg_ready_o=0 while rst_n_i is low, then 1 in IDLE. All other outputs are 0. State IDLE, counters 0.
- Write latency: a payload word accepted at edge k produces strobe, data and address on the outputs during cycle k..k+1, i.e. visible after edge k.
- Outputs are registered. The strobe is high for exactly one cycle per accepted word.
- Back-to-back accepts give one strobe per cycle, with the address incrementing by 1 each cycle.
- cfg_ready_o is combinational from state and core_busy_i only; it does not depend on cfg_valid_i.
- done_o rises in the same cycle as the last write strobe; for L=0, in the cycle after the header accept.
- Next header can be accepted no earlier than the cycle after DONE; minimum packet period is L+2 cycles.
- Asynchronous reset mid-packet: outputs drop to 0 immediately and the partial packet is abandoned; a write strobe already on the output is withdrawn.

## Test plan
- Header T=0, L=3, A=0x0010, then payload 0xAAAA0001..0xAAAA0003 with valid held high -> enable=9'b000000001 for 3 consecutive cycles at addresses 0x10, 0x11, 0x12 with matching data. done_o rises with the third strobe; err_o=0.
- Header T=8, L=2, A=0xFFFF -> strobes on bit 8 at 0xFFFF then 0x0000 (wrap); done_o pulses once.
- Header T=12, L=2, then two payload words -> no strobes; done_o=1 and err_o=1 in the same cycle; the next header is accepted normally.
- T=1, L=4 with core_busy_i=1 after the 2nd accepted word for 5 cycles -> cfg_ready_o=0 for those 5 cycles and no strobes. Words 3 and 4 are written to A+2 and A+3 after release; single done_o.
- T=2, L=4: assert abort_i after 2 writes -> busy_o=0 next cycle, no done_o, no further strobes. Header L=0 -> done_o one cycle after the accept, no strobe.
- Assert rst_n_i low mid-WRITE -> all outputs 0 asynchronously. After release, cfg_ready_o=1 and a fresh T=0, L=1 packet writes correctly.
